// File: rtl/led_prog_loader_pkg.sv
// Shared constants for the LED CPU program loader.
// Holds the frame sync byte, the RAM word and address widths, and the loader FSM state codes.
// Also holds a helper that turns the 8-bit length byte into a word count.
package led_prog_loader_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 8;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // State codes are plain constants so the FSM reads like the LED CPU core.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEN  = 3'd1;
  localparam logic [2:0] ST_HI   = 3'd2;
  localparam logic [2:0] ST_LO   = 3'd3;
  localparam logic [2:0] ST_WR   = 3'd4;
  localparam logic [2:0] ST_CHK  = 3'd5;

  // A length byte of 0 stands for a full 256-word program.
  function automatic logic [8:0] word_count(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/led_prog_loader_timeout.sv
// Inter-byte idle timer for the program loader.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset
//   run     - loader is inside a frame and waiting for a byte
//   kick    - a byte was accepted this cycle; restart the count
//   expired - idle count has reached TIMEOUT while running
module led_prog_loader_timeout #(
  parameter int unsigned TIMEOUT = 50_000_000 / 10
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic kick,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] timer_q;

  always_ff @(posedge clk) begin
    if (rst || !run || kick) begin
      timer_q <= '0;
    end else if (timer_q != CW'(TIMEOUT)) begin
      // Saturate so a stalled FSM still sees expired.
      timer_q <= timer_q + CW'(1);
    end
  end

  assign expired = run && (timer_q == CW'(TIMEOUT));

endmodule

// File: rtl/led_prog_loader.sv
// Writer side of the LED CPU program RAM.
// Parses frames of the form 0xA5, N, N x {hi, lo}, CHK and writes each {hi, lo} word into the
// RAM. The LED CPU is held in reset from the sync byte until a frame with a good checksum ends.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   inByte    - stream byte, taken when inValid && inReady
//   inValid   - inByte valid
//   inReady   - loader can accept a byte (low only during the RAM write cycle)
//   wrEn      - one-cycle RAM write strobe
//   wrAddr    - RAM write address
//   wrData    - RAM write data {hi, lo}
//   cpuRst    - active-high reset to the LED CPU core
//   loadDone  - one-cycle pulse after a good checksum
//   loadErr   - sticky error (bad checksum or timeout), cleared by the next sync byte
module led_prog_loader
  import led_prog_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 50_000_000 / 10,
  parameter bit          BOOT_HOLD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        inByte,
  input  logic              inValid,
  output logic              inReady,
  output logic              wrEn,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [WORD_W-1:0] wrData,
  output logic              cpuRst,
  output logic              loadDone,
  output logic              loadErr
);

  logic [2:0]        state_q, state_d;
  logic [7:0]        sum_q, sum_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              ready_q, ready_d;
  logic              wr_en_q, wr_en_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic accept;
  logic run;
  logic expired;

  assign accept = inValid && ready_q;
  assign run    = (state_q == ST_LEN) || (state_q == ST_HI) ||
                  (state_q == ST_LO)  || (state_q == ST_CHK);

  led_prog_loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .kick    (accept),
    .expired (expired)
  );

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cpu_rst_d = cpu_rst_q;
    err_d     = err_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept && (inByte == SYNC_BYTE)) begin
          state_d   = ST_LEN;
          cpu_rst_d = 1'b1;
          err_d     = 1'b0;
          sum_d     = 8'd0;
          addr_d    = '0;
        end
      end
      ST_LEN: begin
        if (accept) begin
          cnt_d   = word_count(inByte);
          sum_d   = sum_q + inByte;
          state_d = ST_HI;
        end
      end
      ST_HI: begin
        if (accept) begin
          hi_d    = inByte;
          sum_d   = sum_q + inByte;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (accept) begin
          data_d  = {hi_q, inByte};
          sum_d   = sum_q + inByte;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        // The strobe is live in this cycle; move on to the next word slot.
        addr_d  = addr_q + ADDR_W'(1);
        cnt_d   = cnt_q - 9'd1;
        state_d = (cnt_q == 9'd1) ? ST_CHK : ST_HI;
      end
      ST_CHK: begin
        if (accept) begin
          if (inByte == sum_q) begin
            cpu_rst_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // An accepted byte clears the timer, so it wins over a same-cycle timeout.
    if (expired && !accept) begin
      state_d   = ST_IDLE;
      err_d     = 1'b1;
      cpu_rst_d = 1'b1;
    end

    ready_d = (state_d != ST_WR);
    wr_en_d = (state_d == ST_WR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sum_q     <= 8'd0;
      cnt_q     <= 9'd0;
      hi_q      <= 8'd0;
      addr_q    <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      cpu_rst_q <= BOOT_HOLD;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      wr_en_q   <= wr_en_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign inReady  = ready_q;
  assign wrEn     = wr_en_q;
  assign wrAddr   = addr_q;
  assign wrData   = data_q;
  assign cpuRst   = cpu_rst_q;
  assign loadDone = done_q;
  assign loadErr  = err_q;

endmodule

// File: tb/tb_led_prog_loader.sv
// Self-checking bench for led_prog_loader.
// Frames are generated with $urandom; a frame-level reference model parses each byte list and
// predicts the RAM writes, the final address and the checksum outcome.
module tb_led_prog_loader;

  localparam int unsigned TO = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  inByte;
  logic        inValid;
  logic        inReady;
  logic        wrEn;
  logic [7:0]  wrAddr;
  logic [15:0] wrData;
  logic        cpuRst;
  logic        loadDone;
  logic        loadErr;

  always #5 clk = ~clk;

  led_prog_loader #(
    .TIMEOUT   (TO),
    .BOOT_HOLD (1'b0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .inByte   (inByte),
    .inValid  (inValid),
    .inReady  (inReady),
    .wrEn     (wrEn),
    .wrAddr   (wrAddr),
    .wrData   (wrData),
    .cpuRst   (cpuRst),
    .loadDone (loadDone),
    .loadErr  (loadErr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write / done monitor.
  logic [7:0]  obs_addr[$];
  logic [15:0] obs_data[$];
  int          done_cnt = 0;
  logic        prev_wr  = 1'b0;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (wrEn === 1'b1) begin
        obs_addr.push_back(wrAddr);
        obs_data.push_back(wrData);
        check("wr_ready_low", 32'(inReady), 32'd0);
        check("wr_single_cycle", 32'(prev_wr), 32'd0);
      end
      if (loadDone === 1'b1) done_cnt = done_cnt + 1;
    end
    prev_wr <= wrEn;
  end

  // Reference model: frame-level parse from the byte list.
  logic [7:0]  frame_q[$];
  logic [15:0] exp_words[$];
  bit          exp_good;
  int          exp_n;
  int          exp_sync;

  task automatic model_frame();
    int i;
    int sum;
    i = 0;
    exp_words.delete();
    while (i < frame_q.size() && frame_q[i] != 8'hA5) i++;
    exp_sync = i;
    i++;
    exp_n = (frame_q[i] == 8'd0) ? 256 : int'(frame_q[i]);
    sum   = int'(frame_q[i]);
    i++;
    for (int w = 0; w < exp_n; w++) begin
      exp_words.push_back({frame_q[i], frame_q[i+1]});
      sum += int'(frame_q[i]) + int'(frame_q[i+1]);
      i += 2;
    end
    exp_good = ((sum % 256) == int'(frame_q[i]));
  endtask

  task automatic build_frame(input int n, input bit bad, input int npre);
    int         sum;
    logic [7:0] b;
    logic [7:0] chk;
    frame_q.delete();
    repeat (npre) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h00;
      frame_q.push_back(b);
    end
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'(n));
    sum = n;
    for (int w = 0; w < n; w++) begin
      b = 8'($urandom_range(0, 255));
      frame_q.push_back(b);
      sum += int'(b);
      b = 8'($urandom_range(0, 255));
      frame_q.push_back(b);
      sum += int'(b);
    end
    chk = 8'(sum);
    if (bad) chk = chk + 8'($urandom_range(1, 255));
    frame_q.push_back(chk);
  endtask

  // Called away from the clock edge; returns #1 after the edge that took the byte.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      inValid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    inByte  = b;
    inValid = 1'b1;
    n = 0;
    while (inReady !== 1'b1 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n == 10) check("ready_wait", 32'(inReady), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_inReady"}, 32'(inReady), 32'd0);
    check({tag, "_wrEn"}, 32'(wrEn), 32'd0);
    check({tag, "_wrAddr"}, 32'(wrAddr), 32'd0);
    check({tag, "_wrData"}, 32'(wrData), 32'd0);
    check({tag, "_cpuRst"}, 32'(cpuRst), 32'd0);
    check({tag, "_loadDone"}, 32'(loadDone), 32'd0);
    check({tag, "_loadErr"}, 32'(loadErr), 32'd0);
  endtask

  task automatic run_frame(input string tag, input int maxgap);
    int m;
    model_frame();
    obs_addr.delete();
    obs_data.delete();
    done_cnt = 0;
    for (int k = 0; k < frame_q.size(); k++) begin
      send_byte(frame_q[k], $urandom_range(0, maxgap));
      if (k == exp_sync) begin
        @(negedge clk);
        check({tag, "_cpuRst_held"}, 32'(cpuRst), 32'd1);
        check({tag, "_loadErr_cleared"}, 32'(loadErr), 32'd0);
      end
    end
    inValid = 1'b0;
    @(negedge clk);
    check({tag, "_loadDone"}, 32'(loadDone), 32'(exp_good));
    check({tag, "_cpuRst_end"}, 32'(cpuRst), 32'(!exp_good));
    check({tag, "_loadErr_end"}, 32'(loadErr), 32'(!exp_good));
    @(negedge clk);
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'(exp_good));
    check({tag, "_wrAddr_end"}, 32'(wrAddr), 32'(exp_n % 256));
    check({tag, "_write_count"}, 32'(obs_addr.size()), 32'(exp_n));
    m = (obs_addr.size() < exp_n) ? obs_addr.size() : exp_n;
    for (int i = 0; i < m; i++) begin
      check({tag, "_wr_addr"}, 32'(obs_addr[i]), 32'(i % 256));
      check({tag, "_wr_data"}, 32'(obs_data[i]), 32'(exp_words[i]));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    inValid = 1'b0;
    inByte  = 8'h00;
    @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Two-word frame; checksum covers N: 02+F0+04+00+00 = F6.
    frame_q = '{8'hA5, 8'h02, 8'hF0, 8'h04, 8'h00, 8'h00, 8'hF6};
    run_frame("good2", 0);

    // Same frame, wrong checksum.
    frame_q = '{8'hA5, 8'h02, 8'hF0, 8'h04, 8'h00, 8'h00, 8'hF5};
    run_frame("badchk", 0);

    // Stall inside a frame until the timeout fires.
    obs_addr.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    inValid = 1'b0;
    repeat (TO - 1) @(negedge clk);
    check("timeout_early_err", 32'(loadErr), 32'd0);
    repeat (3) @(negedge clk);
    check("timeout_err", 32'(loadErr), 32'd1);
    check("timeout_idle_ready", 32'(inReady), 32'd1);
    check("timeout_cpuRst", 32'(cpuRst), 32'd1);
    check("timeout_no_write", 32'(obs_addr.size()), 32'd0);

    // Full 256-word frame, word i = {i, 01}.
    begin
      int sum;
      frame_q.delete();
      frame_q.push_back(8'hA5);
      frame_q.push_back(8'h00);
      sum = 0;
      for (int i = 0; i < 256; i++) begin
        frame_q.push_back(8'(i));
        frame_q.push_back(8'h01);
        sum += i + 1;
      end
      frame_q.push_back(8'(sum));
    end
    run_frame("full256", 0);

    // Junk before sync, inValid held high through every write cycle.
    frame_q = '{8'h11, 8'h22, 8'hA5, 8'h02, 8'hF0, 8'h04, 8'h00, 8'h00, 8'hF6};
    run_frame("prefix", 0);

    // Reset after the third data byte.
    build_frame(3, 1'b0, 0);
    obs_addr.delete();
    for (int k = 0; k < 5; k++) send_byte(frame_q[k], 0);
    rst     = 1'b1;
    inValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset("midrst");
    check("midrst_partial_writes", 32'(obs_addr.size()), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    build_frame(4, 1'b0, 1);
    run_frame("after_rst", 2);

    // Randomized frames.
    for (int f = 0; f < 8; f++) begin
      build_frame($urandom_range(1, 6), ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
      run_frame("rand", 3);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
